qsn_merge_len15: RTL and testbench

//  Merge/output stage directly downstream of the 15-wide QSN left and right cyclic shifters.

---
 rtl/qsn_merge_len15.sv | 149 ++++++++++++++
 tb/tb_qsn_merge_len15.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/qsn_merge_len15.sv
// Merge/output stage behind the QSN left/right cyclic shifters.
// Tracks each accepted shift factor through the shifter latency and builds the
// per-bit select mask. It merges the two shifter results and buffers the merged
// vectors in a small credit-paced FIFO.
module qsn_merge_len15 #(
  parameter int PC          = 15,
  parameter int SEL_W       = 4,
  parameter int SHIFTER_LAT = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_shift,
  output logic             in_ready,
  input  logic [PC-1:0]    right_in,
  input  logic [PC-1:0]    left_in,
  output logic [PC-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] fifo_level,
  output logic             err_shift
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CRD_W = 8;

  // Upper s bits come from the left shifter; s=0 selects the right shifter only.
  function automatic logic [PC-1:0] build_mask(input logic [SEL_W-1:0] s);
    logic [PC-1:0] m;
    m = '0;
    for (int j = 0; j < PC; j++) begin
      m[j] = (j >= (PC - int'(s)));
    end
    return m;
  endfunction

  function automatic logic [PC-1:0] merge_bits(input logic [PC-1:0] r,
                                               input logic [PC-1:0] l,
                                               input logic [PC-1:0] m);
    return (l & m) | (r & ~m);
  endfunction

  logic             accept;
  logic             shift_bad;
  logic [SEL_W-1:0] shift_clean;

  logic             dly_vld_q [SHIFTER_LAT];
  logic [SEL_W-1:0] dly_sft_q [SHIFTER_LAT];

  logic             stage_vld;
  logic [SEL_W-1:0] stage_sft;
  logic [PC-1:0]    merged;

  logic [PC-1:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SEL_W-1:0] level_q, level_d;
  logic             err_q, err_d;
  logic             push, pop;
  logic [CRD_W-1:0] credit_used;

  assign accept      = in_valid & in_ready;
  assign shift_bad   = (32'(in_shift) >= PC);
  assign shift_clean = shift_bad ? '0 : in_shift;

  // Delay-line valid bits follow the shifter pipeline and are cleared by reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      for (int i = 0; i < SHIFTER_LAT; i++) dly_vld_q[i] <= 1'b0;
    end else begin
      dly_vld_q[0] <= accept;
      for (int i = 1; i < SHIFTER_LAT; i++) dly_vld_q[i] <= dly_vld_q[i-1];
    end
  end

  // Delay-line shift factors are data only; an illegal factor is stored as 0.
  always_ff @(posedge sys_clk) begin
    dly_sft_q[0] <= shift_clean;
    for (int i = 1; i < SHIFTER_LAT; i++) dly_sft_q[i] <= dly_sft_q[i-1];
  end

  assign stage_vld = dly_vld_q[SHIFTER_LAT-1];
  assign stage_sft = dly_sft_q[SHIFTER_LAT-1];
  assign merged    = merge_bits(right_in, left_in, build_mask(stage_sft));

  assign out_valid = (level_q != '0);
  assign push      = stage_vld;
  assign pop       = out_valid & out_ready;

  // Next-state for FIFO pointers, occupancy and the sticky shift error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    err_d    = err_q | (accept & shift_bad);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // FIFO control state register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      err_q    <= err_d;
    end
  end

  // FIFO storage: written at the tail whenever an aligned vector arrives.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= merged;
  end

  // Occupancy must stay in range, and credits must prevent pushing into a full FIFO.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      assert (32'(level_q) <= FIFO_DEPTH)
        else $error("fifo_level out of range: %0d", level_q);
      assert (!(push && !pop && (32'(level_q) == FIFO_DEPTH)))
        else $error("push into full FIFO");
    end
  end

  // Credits in use are counted from registers only, so out_ready never reaches in_ready.
  always_comb begin
    credit_used = CRD_W'(level_q);
    for (int i = 0; i < SHIFTER_LAT; i++) begin
      credit_used = credit_used + CRD_W'(dly_vld_q[i]);
    end
  end

  assign in_ready   = (credit_used < CRD_W'(FIFO_DEPTH)) & ~rst;
  assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign err_shift  = err_q;

endmodule

// File: tb/tb_qsn_merge_len15.sv
// Self-checking bench for qsn_merge_len15: directed tests plus a random run
// against a queue-based reference model of the merge FIFO.
module tb_qsn_merge_len15;

  logic        sys_clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_shift;
  logic        in_ready;
  logic [14:0] right_in;
  logic [14:0] left_in;
  logic [14:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_level;
  logic        err_shift;

  qsn_merge_len15 dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_shift   (in_shift),
    .in_ready   (in_ready),
    .right_in   (right_in),
    .left_in    (left_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .err_shift  (err_shift)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [14:0] exp_q[$];
  logic        pend   = 1'b0;
  logic [3:0]  pend_s = '0;
  logic        err_m  = 1'b0;
  int          n_acc  = 0;
  int          n_out  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Upper s bits from left, remaining bits from right; s>=15 behaves as 0.
  function automatic logic [14:0] ref_merge(input logic [3:0] s,
                                            input logic [14:0] r,
                                            input logic [14:0] l);
    int k;
    int mask;
    k    = (s >= 15) ? 0 : int'(s);
    mask = ((1 << k) - 1) << (15 - k);
    return (l & 15'(mask)) | (r & ~15'(mask));
  endfunction

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input logic iv, input logic [3:0] sh, input logic ordy,
                      input logic [14:0] r, input logic [14:0] l);
    int          sz;
    logic        exp_rdy;
    logic        acc;
    logic        pp;
    logic [14:0] m;
    in_valid  = iv;
    in_shift  = sh;
    out_ready = ordy;
    right_in  = r;
    left_in   = l;
    #1;
    sz      = exp_q.size();
    exp_rdy = ((sz + int'(pend)) < 4);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(sz != 0));
    chk("fifo_level", 32'(fifo_level), 32'(sz));
    chk("err_shift", 32'(err_shift), 32'(err_m));
    if (sz != 0) chk("out_data", 32'(out_data), 32'(exp_q[0]));
    acc = iv && exp_rdy;
    pp  = (sz != 0) && ordy;
    m   = ref_merge(pend_s, r, l);
    @(posedge sys_clk);
    if (pp) begin
      void'(exp_q.pop_front());
      n_out++;
    end
    if (pend) exp_q.push_back(m);
    if (acc && sh >= 4'd15) err_m = 1'b1;
    pend   = acc;
    pend_s = sh;
    if (acc) n_acc++;
    @(negedge sys_clk);
  endtask

  task automatic do_reset(input int n);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready_hold", 32'(in_ready), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
    end
    rst = 1'b0;
    exp_q.delete();
    pend  = 1'b0;
    err_m = 1'b0;
  endtask

  function automatic logic [14:0] rnd15();
    return 15'($urandom);
  endfunction

  initial begin
    int n0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_shift  = '0;
    out_ready = 1'b0;
    right_in  = '0;
    left_in   = '0;
    @(negedge sys_clk);
    do_reset(2);
    #1;
    chk("init_in_ready", 32'(in_ready), 32'd1);
    chk("init_level", 32'(fifo_level), 32'd0);
    chk("init_err", 32'(err_shift), 32'd0);

    // T2: shift 0 selects the right shifter only, 2 cycles after accept
    step(1'b1, 4'd0, 1'b1, rnd15(), rnd15());
    step(1'b0, 4'd0, 1'b1, 15'h1234, 15'h7FFF);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'h1234);
    step(1'b0, 4'd0, 1'b1, rnd15(), rnd15());

    // T3: shift 5 takes bits 14..10 from the left shifter
    step(1'b1, 4'd5, 1'b1, rnd15(), rnd15());
    step(1'b0, 4'd0, 1'b1, 15'h0000, 15'h7FFF);
    chk("t3_data", 32'(out_data), 32'h7C00);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, rnd15(), rnd15());

    // T4: backpressure fills exactly four credits
    n0 = n_acc;
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom_range(0, 14)), 1'b0, rnd15(), rnd15());
    chk("t4_accepts", 32'(n_acc - n0), 32'd4);
    chk("t4_in_ready_full", 32'(in_ready), 32'd0);
    chk("t4_level_full", 32'(fifo_level), 32'd4);
    step(1'b0, 4'd0, 1'b1, rnd15(), rnd15());
    chk("t4_ready_after_pop", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b0, 4'd0, 1'b1, rnd15(), rnd15());
    chk("t4_drained", 32'(fifo_level), 32'd0);

    // T5: back-to-back streaming over every legal shift
    n0 = n_out;
    for (int s = 0; s < 15; s++) begin
      if (s >= 2) chk("t5_no_bubble", 32'(out_valid), 32'd1);
      step(1'b1, 4'(s), 1'b1, rnd15(), rnd15());
    end
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1, rnd15(), rnd15());
    chk("t5_outputs", 32'(n_out - n0), 32'd15);

    // T6: illegal shift merges as shift 0 and sets the sticky error
    step(1'b1, 4'd15, 1'b1, rnd15(), rnd15());
    chk("t6_err_set", 32'(err_shift), 32'd1);
    step(1'b0, 4'd0, 1'b1, 15'h2AAA, 15'h5555);
    chk("t6_data", 32'(out_data), 32'h2AAA);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1, rnd15(), rnd15());
    chk("t6_err_sticky", 32'(err_shift), 32'd1);

    // T1: reset mid-stream with two buffered vectors
    step(1'b1, 4'd3, 1'b0, rnd15(), rnd15());
    step(1'b1, 4'd7, 1'b0, rnd15(), rnd15());
    step(1'b0, 4'd0, 1'b0, rnd15(), rnd15());
    chk("t1_level_before", 32'(fifo_level), 32'd2);
    do_reset(3);
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_level", 32'(fifo_level), 32'd0);
    chk("t1_err", 32'(err_shift), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    @(negedge sys_clk);

    // Random traffic, including illegal shifts and launches without credit
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 2) != 0), rnd15(), rnd15());
    end
    for (int i = 0; i < 8; i++) step(1'b0, 4'd0, 1'b1, rnd15(), rnd15());
    chk("final_drained", 32'(fifo_level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
